// File: rtl/uart_cmd_wrapper.sv
// UART front end: 8N1 receiver pairing bytes into 16-bit commands (high byte first),
// plus an independent 8N1 transmitter for one-byte responses.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int BYTE_TO  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        tx_busy,
  output logic        resp_sent
);

  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV);
  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2);
  localparam logic [15:0] LAST_CLK = 16'(BAUD_DIV - 1);
  localparam logic [15:0] TO_LIMIT = 16'(BYTE_TO);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {AS_WAIT_HI, AS_WAIT_LO}               as_state_t;
  typedef enum logic       {TX_IDLE, TX_XMIT}                     tx_state_t;

  rx_state_t   rx_state, rx_next;
  as_state_t   as_state, as_next;
  tx_state_t   tx_state, tx_next;

  logic        rx_p0, rx_p1, rx_p2;
  logic        rx_fall, rx_tick, byte_ok, byte_rdy;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;

  logic        load_hi, load_lo, to_expired;
  logic [15:0] to_div, to_cnt;

  logic        tx_start, tx_done;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bits;
  logic [8:0]  tx_shift;

  // Stage p0..p2: RX synchronizer plus one extra flop for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign rx_fall = rx_p2 & ~rx_p1;
  assign rx_tick = (rx_cnt == 16'd1);

  // Receiver: sample points are counter expiries, mid-bit after the half-bit start offset
  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    byte_ok = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bits == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) begin
                  rx_next = RX_IDLE;
                  byte_ok = rx_p1;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= 16'd0;
      rx_bits  <= 3'd0;
      byte_rdy <= 1'b0;
    end else begin
      byte_rdy <= byte_ok;
      if (rx_state == RX_IDLE) begin
        rx_bits <= 3'd0;
        if (rx_fall) rx_cnt <= HALF_BIT;
      end else if (rx_tick) begin
        rx_cnt <= FULL_BIT;
        if (rx_state == RX_DATA) rx_bits <= rx_bits + 3'd1;
      end else begin
        rx_cnt <= rx_cnt - 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((rx_state == RX_DATA) && rx_tick) rx_shift <= {rx_p1, rx_shift[7:1]};
  end

  // Assembler: the inter-byte timeout only runs while the receiver is idle
  assign to_expired = (to_cnt == TO_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) as_state <= AS_WAIT_HI;
    else     as_state <= as_next;
  end

  always_comb begin
    as_next = as_state;
    load_hi = 1'b0;
    load_lo = 1'b0;
    case (as_state)
      AS_WAIT_HI: if (byte_rdy) begin
                    load_hi = 1'b1;
                    as_next = AS_WAIT_LO;
                  end
      AS_WAIT_LO: if (byte_rdy) begin
                    load_lo = 1'b1;
                    as_next = AS_WAIT_HI;
                  end else if (to_expired) begin
                    as_next = AS_WAIT_HI;
                  end
      default:    as_next = AS_WAIT_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_div <= 16'd0;
      to_cnt <= 16'd0;
    end else if (load_hi) begin
      to_div <= 16'd0;
      to_cnt <= 16'd0;
    end else if ((as_state == AS_WAIT_LO) && (rx_state == RX_IDLE)) begin
      if (to_div == LAST_CLK) begin
        to_div <= 16'd0;
        to_cnt <= to_cnt + 16'd1;
      end else begin
        to_div <= to_div + 16'd1;
      end
    end
  end

  // A fresh high byte drops any command the consumer never acknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= 16'h0000;
      cmd_rdy <= 1'b0;
    end else if (load_hi) begin
      cmd[15:8] <= rx_shift;
      cmd_rdy   <= 1'b0;
    end else if (load_lo) begin
      cmd[7:0] <= rx_shift;
      cmd_rdy  <= 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

  // Transmitter: start bit goes out on the accept edge, the rest shift from tx_shift
  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next  = tx_state;
    tx_start = 1'b0;
    tx_done  = 1'b0;
    case (tx_state)
      TX_IDLE: if (send_resp) begin
                 tx_start = 1'b1;
                 tx_next  = TX_XMIT;
               end
      TX_XMIT: if ((tx_cnt == 16'd0) && (tx_bits == 4'd9)) begin
                 tx_done = 1'b1;
                 tx_next = TX_IDLE;
               end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      TX        <= 1'b1;
      tx_cnt    <= 16'd0;
      tx_bits   <= 4'd0;
      resp_sent <= 1'b0;
    end else begin
      resp_sent <= tx_done;
      if (tx_start) begin
        TX      <= 1'b0;
        tx_cnt  <= LAST_CLK;
        tx_bits <= 4'd0;
      end else if (tx_state == TX_XMIT) begin
        if (tx_cnt == 16'd0) begin
          tx_cnt <= LAST_CLK;
          if (tx_bits != 4'd9) begin
            TX      <= tx_shift[0];
            tx_bits <= tx_bits + 4'd1;
          end else begin
            TX <= 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_start) begin
      tx_shift <= {1'b1, resp};
    end else if ((tx_state == TX_XMIT) && (tx_cnt == 16'd0) && (tx_bits != 4'd9)) begin
      tx_shift <= {1'b1, tx_shift[8:1]};
    end
  end

  assign tx_busy = (tx_state == TX_XMIT);

endmodule
